// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: opcode constants, FSM states, instruction
// classes and the encodings of the datapath select/operation fields.
// The immediate generator imports the same opcode constants from here.
package cpu_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_LSW = 3'b010;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_NONE
  } cls_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_CMP = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCA_RS1   = 2'd0,
    SRCA_PC    = 2'd1,
    SRCA_OLDPC = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } src_b_e;

  typedef enum logic [1:0] {
    WBS_ALU = 2'd0,
    WBS_MEM = 2'd1,
    WBS_PC4 = 2'd2
  } wb_sel_e;

  // States in which the controller waits on a memory handshake.
  function automatic logic is_wait_state(input state_e s);
    return (s == FETCH) || (s == MEM);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps the held instruction onto the
// class the FSM dispatches on, plus the few field flags the FSM needs.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output cls_e        cls,
  output logic        is_sub,
  output logic        uses_imm,
  output logic        is_blt,
  output logic        rd_zero,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_rest_zero;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign f7_rest_zero  = ({instr[31], instr[29:25]} == 6'd0);
  assign rd_zero       = (instr[11:7] == 5'd0);
  assign is_blt        = (funct3 == F3_BLT);
  assign illegal       = (cls == CLS_NONE);
  assign unused_fields = ^instr[24:15];

  // Classify the opcode; anything outside the supported subset is CLS_NONE.
  always_comb begin
    cls      = CLS_NONE;
    is_sub   = 1'b0;
    uses_imm = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        if (funct3 == F3_ADD) begin
          cls      = CLS_ALU;
          uses_imm = 1'b1;
        end
      end
      OPC_OP: begin
        if (funct3 == F3_ADD && f7_rest_zero) begin
          cls    = CLS_ALU;
          is_sub = instr[30];
        end
      end
      OPC_AUIPC: cls = CLS_AUIPC;
      OPC_JAL:   cls = CLS_JAL;
      OPC_JALR:  cls = CLS_JALR;
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BLT) cls = CLS_BRANCH;
      end
      OPC_LOAD: begin
        if (funct3 == F3_LSW) cls = CLS_LOAD;
      end
      OPC_STORE: begin
        if (funct3 == F3_LSW) cls = CLS_STORE;
      end
      default: cls = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Drives datapath enables and selects, watches memory handshakes with a
// timeout, and raises a sticky illegal flag on bad opcodes or timeouts.
// Optional retired-instruction counter: define MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TO = 16
`ifdef MULTICYCLE_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             pc_sel,
  output logic             illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] instret
`endif
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TO - 1);

  state_e     state;
  state_e     next_state;
  logic [7:0] to_cnt;
  logic       to_expired;
  logic       illegal_q;
  logic       set_illegal;
  logic       retire;
  logic       taken;

  cls_e       cls;
  logic       is_sub;
  logic       uses_imm;
  logic       is_blt;
  logic       rd_zero;
  logic       dec_illegal;

  ctrl_decode u_decode (
    .instr    (instr),
    .cls      (cls),
    .is_sub   (is_sub),
    .uses_imm (uses_imm),
    .is_blt   (is_blt),
    .rd_zero  (rd_zero),
    .illegal  (dec_illegal)
  );

  assign to_expired = is_wait_state(state) && !mem_ready && (to_cnt == TO_LAST);
  assign taken      = is_blt ? alu_lt : alu_zero;
  assign illegal    = !rst && (illegal_q || set_illegal);

  // Next-state and output decode; reset masks every enable in the same cycle.
  always_comb begin
    next_state   = state;
    set_illegal  = 1'b0;
    retire       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_a    = SRCA_RS1;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALU_ADD;
    wb_sel       = WBS_ALU;
    pc_sel       = 1'b0;
    unique case (state)
      FETCH: begin
        mem_re    = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          next_state = DECODE;
        end else if (to_expired) begin
          set_illegal = 1'b1;
          next_state  = HALT;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (dec_illegal) begin
          set_illegal = 1'b1;
          next_state  = HALT;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        case (cls)
          CLS_ALU: begin
            alu_src_b  = uses_imm ? SRCB_IMM : SRCB_RS2;
            alu_op     = is_sub ? ALU_SUB : ALU_ADD;
            next_state = WB;
          end
          CLS_AUIPC: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_IMM;
            next_state = WB;
          end
          CLS_BRANCH: begin
            alu_op     = ALU_SUB;
            retire     = 1'b1;
            next_state = FETCH;
            if (taken) begin
              pc_we  = 1'b1;
              pc_sel = 1'b1;
            end
          end
          CLS_JAL: begin
            pc_we      = 1'b1;
            pc_sel     = 1'b1;
            next_state = WB;
          end
          CLS_JALR: begin
            alu_src_b  = SRCB_IMM;
            pc_we      = 1'b1;
            next_state = WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_b  = SRCB_IMM;
            next_state = MEM;
          end
          default: begin
            set_illegal = 1'b1;
            next_state  = HALT;
          end
        endcase
      end
      MEM: begin
        alu_src_b    = SRCB_IMM;
        mem_addr_sel = 1'b1;
        mem_re       = (cls == CLS_LOAD);
        mem_we       = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_LOAD) begin
            next_state = WB;
          end else begin
            retire     = 1'b1;
            next_state = FETCH;
          end
        end else if (to_expired) begin
          set_illegal = 1'b1;
          next_state  = HALT;
        end
      end
      WB: begin
        rf_we      = !rd_zero;
        retire     = 1'b1;
        next_state = FETCH;
        if (cls == CLS_LOAD) begin
          wb_sel = WBS_MEM;
        end else if (cls == CLS_JAL || cls == CLS_JALR) begin
          wb_sel = WBS_PC4;
        end
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
    if (rst) begin
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      rf_we  = 1'b0;
      mem_re = 1'b0;
      mem_we = 1'b0;
    end
  end

  // State register; reset returns to FETCH regardless of any pending handshake.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  // Sticky illegal flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)              illegal_q <= 1'b0;
    else if (set_illegal) illegal_q <= 1'b1;
  end

  // Memory-wait counter restarts whenever a wait state is entered.
  always_ff @(posedge clk) begin
    if (rst)                                           to_cnt <= 8'd0;
    else if (next_state != state || !is_wait_state(state)) to_cnt <= 8'd0;
    else                                               to_cnt <= to_cnt + 8'd1;
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (rst)         instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: table of single instructions run with
// mem_ready always high through a scoreboard, plus hand-written sequences
// for memory waits, timeout, illegal opcode and reset during MEM.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        alu_zero;
  logic        alu_lt;
  logic        mem_ready;
  logic        ir_we, pc_we, rf_we, mem_re, mem_we, mem_addr_sel;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel;
  logic        pc_sel, illegal;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [3:0]  instret;
`endif

  multicycle_ctrl #(
    .MEM_TO (16)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .CNT_W (4)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .alu_zero     (alu_zero),
    .alu_lt       (alu_lt),
    .mem_ready    (mem_ready),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .rf_we        (rf_we),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .wb_sel       (wb_sel),
    .pc_sel       (pc_sel),
    .illegal      (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .instret    (instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    logic        lt;
    logic        ir0;
    int          len;
    int          rf_idx;
    int          rf_cnt;
    logic [1:0]  wb;
    logic        pcwe;
    logic        pcsel;
    logic        chk_alu;
    logic [1:0]  op;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        mre;
    logic        mwe;
    int          viol;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input string nm, input logic [31:0] ins,
                              input logic z, input logic l, input int len,
                              input int rfi, input logic [1:0] wb,
                              input logic pcwe, input logic pcsel,
                              input logic chk, input logic [1:0] op,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic mre, input logic mwe);
    vec_t v;
    v.name = nm; v.instr = ins; v.zero = z; v.lt = l; v.ir0 = 1'b1;
    v.len = len; v.rf_idx = rfi; v.rf_cnt = (rfi >= 0) ? 1 : 0; v.wb = wb;
    v.pcwe = pcwe; v.pcsel = pcsel; v.chk_alu = chk; v.op = op; v.sa = sa;
    v.sb = sb; v.mre = mre; v.mwe = mwe; v.viol = 0;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic check_output(input vec_t o);
    vec_t e;
    if (sb_q.size() == 0) begin
      check({o.name, "/sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "/ir_we_fetch"}, o.ir0, e.ir0);
      check({e.name, "/len"}, o.len, e.len);
      check({e.name, "/rf_idx"}, o.rf_idx, e.rf_idx);
      check({e.name, "/rf_cnt"}, o.rf_cnt, e.rf_cnt);
      check({e.name, "/wb_sel"}, o.wb, e.wb);
      check({e.name, "/exec_pc_we"}, o.pcwe, e.pcwe);
      check({e.name, "/exec_pc_sel"}, o.pcsel, e.pcsel);
      if (e.chk_alu) begin
        check({e.name, "/exec_alu_op"}, o.op, e.op);
        check({e.name, "/exec_src_a"}, o.sa, e.sa);
        check({e.name, "/exec_src_b"}, o.sb, e.sb);
      end
      check({e.name, "/mem_re"}, o.mre, e.mre);
      check({e.name, "/mem_we"}, o.mwe, e.mwe);
      check({e.name, "/onehot"}, o.viol, e.viol);
    end
  endtask

  // Entered in the low phase of a FETCH cycle; returns in the low phase of the next FETCH.
  task automatic apply_stimulus(input vec_t v);
    vec_t o;
    int   n1;
    sb_q.push_back(v);
    instr     = v.instr;
    alu_zero  = v.zero;
    alu_lt    = v.lt;
    mem_ready = 1'b1;
    #1;
    o = v;
    o.ir0 = 1'b0; o.len = -1; o.rf_idx = -1; o.rf_cnt = 0; o.wb = 2'd0;
    o.pcwe = 1'b0; o.pcsel = 1'b0; o.op = 2'd0; o.sa = 2'd0; o.sb = 2'd0;
    o.mre = 1'b0; o.mwe = 1'b0; o.viol = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      if (k > 0 && mem_re && !mem_addr_sel) begin
        o.len = k;
        break;
      end
      if (k == 0) o.ir0 = ir_we;
      if (rf_we) begin
        o.rf_cnt++;
        o.rf_idx = k;
        o.wb     = wb_sel;
      end
      if (k == 2) begin
        o.pcwe  = pc_we;
        o.pcsel = pc_we & pc_sel;
        o.op    = alu_op;
        o.sa    = alu_src_a;
        o.sb    = alu_src_b;
      end
      if (k == 3) begin
        o.mre = mem_re & mem_addr_sel;
        o.mwe = mem_we & mem_addr_sel;
      end
      n1 = int'(pc_we) + int'(rf_we) + int'(ir_we) + int'(mem_we);
      if (n1 > 1 && !(n1 == 2 && ir_we && pc_we)) o.viol++;
    end
    check_output(o);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    int mre_cnt;
    //            name      instr         z     l     len rf  wb    pcwe  pcsel chk   op    sa    sb    mre   mwe
    vecs[0]  = mk("ADDI",   32'h00500093, 1'b0, 1'b0, 4,  3, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0);
    vecs[1]  = mk("ADD",    32'h002081B3, 1'b0, 1'b0, 4,  3, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[2]  = mk("SUB",    32'h402081B3, 1'b0, 1'b0, 4,  3, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[3]  = mk("ADD_x0", 32'h00208033, 1'b0, 1'b0, 4, -1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[4]  = mk("AUIPC",  32'h12345297, 1'b0, 1'b0, 4,  3, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0);
    vecs[5]  = mk("JAL",    32'h008000EF, 1'b0, 1'b0, 4,  3, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[6]  = mk("JALR",   32'h000100E7, 1'b0, 1'b0, 4,  3, 2'd2, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0);
    vecs[7]  = mk("BEQ_t",  32'h00208063, 1'b1, 1'b0, 3, -1, 2'd0, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[8]  = mk("BEQ_n",  32'h00208063, 1'b0, 1'b1, 3, -1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[9]  = mk("BLT_t",  32'h0020C063, 1'b0, 1'b1, 3, -1, 2'd0, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[10] = mk("BLT_n",  32'h0020C063, 1'b1, 1'b0, 3, -1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    vecs[11] = mk("LW",     32'h0080A203, 1'b0, 1'b0, 5,  4, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
    vecs[12] = mk("SW",     32'h0020A423, 1'b0, 1'b0, 4, -1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1);

    instr = 32'h0; alu_zero = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0; rst = 1'b1;
    step();
    step();
    check("rst/ir_we", ir_we, 0);
    check("rst/pc_we", pc_we, 0);
    check("rst/rf_we", rf_we, 0);
    check("rst/mem_re", mem_re, 0);
    check("rst/mem_we", mem_we, 0);
    check("rst/illegal", illegal, 0);
    rst = 1'b0;
    #1;
    check("first_fetch/mem_re", mem_re, 1);
    check("first_fetch/addr_sel", mem_addr_sel, 0);
    check("first_fetch/ir_we_wait", ir_we, 0);

    for (int i = 0; i < NVEC; i++) apply_stimulus(vecs[i]);
    for (int i = 0; i < 4; i++) apply_stimulus(vecs[0]);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("instret_wrap", instret, 1);
`endif

    // LW: fetch waits 12 cycles, then MEM waits 3 cycles before mem_ready.
    $display("[TB] LW with delayed memory");
    instr = 32'h0080A203; mem_ready = 1'b0;
    for (int i = 1; i < 12; i++) step();
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    mre_cnt = 0;
    for (int j = 0; j < 4; j++) begin
      step();
      mem_ready = (j == 3);
      #1;
      if (mem_re && mem_addr_sel) mre_cnt++;
    end
    check("lw_delay/mem_re_cycles", mre_cnt, 4);
    check("lw_delay/illegal", illegal, 0);
    step();
    mem_ready = 1'b0;
    #1;
    check("lw_delay/rf_we", rf_we, 1);
    check("lw_delay/wb_sel", wb_sel, 1);

    // Fetch timeout: 16 cycles without mem_ready.
    $display("[TB] fetch timeout");
    do_reset();
    bad = 0;
    for (int c = 1; c <= 15; c++) begin
      if (c > 1) step();
      if (!mem_re || illegal) bad++;
    end
    check("timeout/early_cycles", bad, 0);
    step();
    check("timeout/illegal_cycle16", illegal, 1);
    step();
    check("timeout/halt_mem_re", mem_re, 0);
    check("timeout/illegal_sticky", illegal, 1);

    // Undecoded opcode halts the FSM until reset.
    $display("[TB] illegal opcode");
    do_reset();
    instr = 32'h0000007F; mem_ready = 1'b1;
    #1;
    check("illop/fetch_ir_we", ir_we, 1);
    step();
    check("illop/decode_illegal", illegal, 1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ir_we || pc_we || rf_we || mem_re || mem_we || !illegal) bad++;
    end
    check("illop/halt_enables", bad, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("illop/rst_illegal", illegal, 0);
    check("illop/rst_fetch", mem_re & ~mem_addr_sel, 1);

    // Reset arriving while a load waits in MEM.
    $display("[TB] reset during MEM");
    instr = 32'h0080A203; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    step();
    check("rstmem/in_mem", mem_re & mem_addr_sel, 1);
    rst = 1'b1;
    step();
    check("rstmem/mem_re_next", mem_re, 0);
    rst = 1'b0;
    #1;
    check("rstmem/refetch", mem_re & ~mem_addr_sel, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
